// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, models fixed mult/div latency
// with a down-counter, and raises a stall for a D-stage HI/LO user while occupied.
module e_mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_is_md,
   output logic        busy,
   output logic        stall,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] mdout
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;
   logic             r_pend_we;

   logic        w_accept;
   logic        w_is_mul;
   logic        w_is_div;
   logic [63:0] w_a_ext;
   logic [63:0] w_b_ext;
   logic [63:0] w_prod;
   logic        w_sdiv;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_b_safe;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_accept = start & (r_cnt == '0);
   assign w_is_mul = (mdop == OP_MULT) | (mdop == OP_MULTU);
   assign w_is_div = (mdop == OP_DIV)  | (mdop == OP_DIVU);

   // Low 64 bits of a product of sign-extended operands equal the signed product.
   assign w_a_ext = (mdop == OP_MULT) ? {{32{A[31]}}, A} : {32'd0, A};
   assign w_b_ext = (mdop == OP_MULT) ? {{32{B[31]}}, B} : {32'd0, B};
   assign w_prod  = w_a_ext * w_b_ext;

   // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
   assign w_sdiv   = (mdop == OP_DIV);
   assign w_a_mag  = (w_sdiv & A[31]) ? (32'd0 - A) : A;
   assign w_b_mag  = (w_sdiv & B[31]) ? (32'd0 - B) : B;
   assign w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag  = w_a_mag / w_b_safe;
   assign w_r_mag  = w_a_mag % w_b_safe;
   assign w_quo    = (w_sdiv & (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_rem    = (w_sdiv & A[31]) ? (32'd0 - w_r_mag) : w_r_mag;

   assign w_res_hi = w_is_mul ? w_prod[63:32] : w_rem;
   assign w_res_lo = w_is_mul ? w_prod[31:0]  : w_quo;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_we <= 1'b0;
      end else begin
         if (w_accept && (w_is_mul || w_is_div)) begin
            r_cnt     <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            // A zero divisor still occupies the unit but leaves HI/LO untouched.
            r_pend_we <= w_is_mul | (B != 32'd0);
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end

         if ((r_cnt == CNT_W'(1)) && r_pend_we) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end else if (w_accept && (mdop == OP_MTHI)) begin
            r_hi <= A;
         end else if (w_accept && (mdop == OP_MTLO)) begin
            r_lo <= A;
         end
      end
   end

   assign busy  = (r_cnt != '0);
   assign stall = D_is_md & (busy | (start & (w_is_mul | w_is_div)));
   assign HI    = r_hi;
   assign LO    = r_lo;

   always_comb begin
      mdout = 32'd0;
      if (mdop == OP_MFHI) begin
         mdout = r_hi;
      end else if (mdop == OP_MFLO) begin
         mdout = r_lo;
      end
   end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: a vector table of HI/LO ops plus hand-written
// sequences for stall timing, start-while-busy and reset during a divide.
module tb_e_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  mdop;
   logic [31:0] A;
   logic [31:0] B;
   logic        D_is_md;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] mdout;

   int n_checks = 0;
   int n_errors = 0;

   e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdop    (mdop),
      .A       (A),
      .B       (B),
      .D_is_md (D_is_md),
      .busy    (busy),
      .stall   (stall),
      .HI      (HI),
      .LO      (LO),
      .mdout   (mdout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      mdop  = op;
      A     = a;
      B     = b;
      @(posedge clk); #1;
      start = 1'b0;
      mdop  = 4'd0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int n;

      vecs[0]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2]  = '{4'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vecs[3]  = '{4'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
      vecs[4]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[5]  = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
      vecs[6]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[7]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
      vecs[8]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[9]  = '{4'd5, 32'h00001234, 32'd0,        32'h00001234, 32'h80000000, 0};
      vecs[10] = '{4'd6, 32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0};
      vecs[11] = '{4'd3, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};
      vecs[12] = '{4'd4, 32'd5,        32'd0,        32'h00001234, 32'h00005678, 10};

      reset   = 1'b1;
      start   = 1'b0;
      mdop    = 4'd0;
      A       = 32'd0;
      B       = 32'd0;
      D_is_md = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(1);

      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      mdop = 4'd7; #1;
      chk("reset_mfhi", mdout, 32'd0);
      mdop = 4'd0;

      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         n = 0;
         while (busy && n < 100) begin
            n++;
            tick(1);
         end
         chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].cyc));
         chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
         mdop = 4'd7; #1;
         chk($sformatf("v%0d_mfhi", i), mdout, vecs[i].hi);
         mdop = 4'd8; #1;
         chk($sformatf("v%0d_mflo", i), mdout, vecs[i].lo);
         mdop = 4'd11; #1;
         chk($sformatf("v%0d_mdout_none", i), mdout, 32'd0);
         mdop = 4'd0;
         $display("vec %0d op=%0d a=%08h b=%08h -> HI=%08h LO=%08h busy=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, HI, LO, n);
      end

      // Stall: mfhi waiting in D while a mult is issued then runs.
      D_is_md = 1'b1;
      start   = 1'b1;
      mdop    = 4'd1;
      A       = 32'h00010000;
      B       = 32'h00030000;
      #1;
      chk("stall_issue", 32'(stall), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      mdop  = 4'd0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall_busy%0d", c + 1), 32'(stall), 32'd1);
         tick(1);
      end
      chk("stall_released", 32'(stall), 32'd0);
      start = 1'b1;
      mdop  = 4'd7;
      #1;
      chk("stall_mf_op", 32'(stall), 32'd0);
      chk("stall_mfhi", mdout, 32'h00000003);
      @(posedge clk); #1;
      start   = 1'b0;
      mdop    = 4'd8; #1;
      chk("stall_mflo", mdout, 32'h00000000);
      mdop    = 4'd0;
      D_is_md = 1'b0;
      $display("stall seq HI=%08h LO=%08h", HI, LO);

      // A second start while busy must be ignored and must not reload the counter.
      issue(4'd1, 32'd2, 32'd3);
      tick(1);
      issue(4'd3, 32'd100, 32'd7);
      n = 2;
      while (busy && n < 100) begin
         n++;
         tick(1);
      end
      chk("ignore_busy_cycles", 32'(n), 32'd5);
      chk("ignore_hi", HI, 32'd0);
      chk("ignore_lo", LO, 32'd6);
      tick(12);
      chk("ignore_hi_late", HI, 32'd0);
      chk("ignore_lo_late", LO, 32'd6);
      chk("ignore_busy_late", 32'(busy), 32'd0);
      $display("ignore seq HI=%08h LO=%08h busy_cycles=%0d", HI, LO, n);

      // Reset during busy cycle 3 of a divide discards the pending result.
      issue(4'd3, 32'd7, 32'd2);
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_hi", HI, 32'd0);
      chk("rst_mid_lo", LO, 32'd0);
      tick(12);
      chk("rst_late_hi", HI, 32'd0);
      chk("rst_late_lo", LO, 32'd0);
      chk("rst_late_busy", 32'(busy), 32'd0);
      $display("reset seq HI=%08h LO=%08h", HI, LO);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
